// File: rtl/ahb_bus_arbiter.sv
// AHB address-phase arbiter with burst-boundary tracking, bus locking and data-phase owner steering.
// Build option: define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  localparam int MW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_d,
  output logic                   hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] HB_INCR   = 3'b001;

  typedef enum logic [1:0] {
    IDLE_BUS,
    BURST,
    INCR_OPEN,
    LOCKED
  } state_t;

  state_t                   state_reg, state_next, bus_state;
  logic [3:0]               cnt_reg, cnt_next;
  logic [NUM_MASTERS-1:0]   grant_reg, grant_next, win_onehot;
  logic [MW-1:0]            master_reg, master_d_reg;
  logic                     mastlock_reg;
  logic [MW-1:0]            owner, winner, idx;
  logic                     owner_lock, owner_req, arb_point, found;

  // Beats remaining after the first one for each fixed burst type.
  function automatic logic [3:0] burst_last(input logic [2:0] b);
    case (b)
      3'b010, 3'b011: burst_last = 4'd3;
      3'b100, 3'b101: burst_last = 4'd7;
      3'b110, 3'b111: burst_last = 4'd15;
      default:        burst_last = 4'd0;
    endcase
  endfunction

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant_reg[i]) owner = MW'(i);
  end

  assign owner_lock = hlock[owner];
  assign owner_req  = hbusreq[owner];

  always_comb begin
    cnt_next = cnt_reg;
    if (hready) begin
      if (htrans == TR_NONSEQ)
        cnt_next = burst_last(hburst);
      else if (htrans == TR_SEQ && cnt_reg != 4'd0)
        cnt_next = cnt_reg - 4'd1;
    end
  end

  // Burst-tracking state ignoring lock; SINGLE and finished bursts fall back to IDLE_BUS.
  always_comb begin
    bus_state = state_reg;
    case (htrans)
      TR_IDLE: bus_state = IDLE_BUS;
      TR_BUSY: bus_state = state_reg;
      TR_NONSEQ: begin
        if (hburst == HB_INCR)     bus_state = INCR_OPEN;
        else if (cnt_next != 4'd0) bus_state = BURST;
        else                       bus_state = IDLE_BUS;
      end
      default: begin
        if (state_reg == INCR_OPEN) bus_state = INCR_OPEN;
        else if (cnt_next != 4'd0)  bus_state = BURST;
        else                        bus_state = IDLE_BUS;
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (hready) begin
      if (owner_lock)               state_next = LOCKED;
      else if (state_reg == LOCKED) state_next = IDLE_BUS;
      else                          state_next = bus_state;
    end
  end

  assign arb_point = hready && (state_reg != LOCKED) && !owner_lock && (htrans != TR_BUSY) &&
                     ((htrans == TR_IDLE) ||
                      (htrans[1] && bus_state == IDLE_BUS) ||
                      (state_reg == INCR_OPEN && !owner_req));

  always_comb begin
    winner = owner;
    found  = 1'b0;
    idx    = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = MW'(i);
      if (!found && hbusreq[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`else
    // Search starts just past the owner and wraps back to it last.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = MW'((int'(owner) + k) % NUM_MASTERS);
      if (!found && hbusreq[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`endif
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
    assign win_onehot[gi] = (winner == MW'(gi));
  end

  assign grant_next = arb_point ? win_onehot : grant_reg;

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      grant_reg    <= NUM_MASTERS'(1);
      master_reg   <= '0;
      master_d_reg <= '0;
      mastlock_reg <= 1'b0;
      cnt_reg      <= 4'd0;
      state_reg    <= IDLE_BUS;
    end else begin
      grant_reg <= grant_next;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (hready) begin
        master_reg   <= owner;
        mastlock_reg <= owner_lock;
        master_d_reg <= master_reg;
      end
    end
  end

  assign hgrant    = grant_reg;
  assign hmaster   = master_reg;
  assign hmaster_d = master_d_reg;
  assign hmastlock = mastlock_reg;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed self-checking bench for ahb_bus_arbiter with two masters.
// Honours ARB_FIXED_PRIO_EN for the alternating-grant expectations.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] WRAP8  = 3'b100;

  logic       hclk = 1'b0;
  logic       hreset = 1'b0;
  logic [1:0] hbusreq = 2'b00;
  logic [1:0] hlock = 2'b00;
  logic [1:0] htrans = 2'b00;
  logic [2:0] hburst = 3'b000;
  logic       hready = 1'b1;
  logic [1:0] hgrant;
  logic       hmaster, hmaster_d, hmastlock;

  int errors = 0;
  int checks = 0;
  int ncyc = 0;
  logic [1:0] exp_alt [4];

  always #5 hclk = ~hclk;

  ahb_bus_arbiter #(.NUM_MASTERS(2)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .hmastlock (hmastlock)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, clock, then settle 1ns past the edge before checks.
  task automatic cyc(input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    htrans = tr;
    hburst = bu;
    hready = rdy;
    @(posedge hclk);
    #1;
    ncyc++;
    $display("cyc %0d htrans=%b hburst=%b hready=%b hbusreq=%b hlock=%b -> hgrant=%b hmaster=%0d hmaster_d=%0d hmastlock=%b",
             ncyc, tr, bu, rdy, hbusreq, hlock, hgrant, hmaster, hmaster_d, hmastlock);
  endtask

  initial begin
`ifdef ARB_FIXED_PRIO_EN
    exp_alt[0] = 2'b01; exp_alt[1] = 2'b01; exp_alt[2] = 2'b01; exp_alt[3] = 2'b01;
`else
    exp_alt[0] = 2'b01; exp_alt[1] = 2'b10; exp_alt[2] = 2'b01; exp_alt[3] = 2'b10;
`endif

    // Reset values
    repeat (3) @(posedge hclk);
    #1;
    check("rst_grant", 8'(hgrant), 8'h01);
    check("rst_master", 8'(hmaster), 8'h0);
    check("rst_master_d", 8'(hmaster_d), 8'h0);
    check("rst_mastlock", 8'(hmastlock), 8'h0);
    hreset = 1'b1;

    // Idle bus parks on master 0
    for (int i = 0; i < 10; i++) begin
      cyc(IDLE, SINGLE, 1'b1);
      check("idle_grant", 8'(hgrant), 8'h01);
      check("idle_master", 8'(hmaster), 8'h0);
    end
    check("idle_master_d", 8'(hmaster_d), 8'h0);
    check("idle_mastlock", 8'(hmastlock), 8'h0);

    // INCR4 by M0, M1 requests at beat 2
    hbusreq = 2'b01;
    cyc(NONSEQ, INCR4, 1'b1); check("incr4_b1_grant", 8'(hgrant), 8'h01);
    hbusreq = 2'b11;
    cyc(SEQ, INCR4, 1'b1);    check("incr4_b2_grant", 8'(hgrant), 8'h01);
    cyc(SEQ, INCR4, 1'b1);    check("incr4_b3_grant", 8'(hgrant), 8'h01);
    hbusreq = 2'b10;
    cyc(SEQ, INCR4, 1'b1);    check("incr4_b4_grant", 8'(hgrant), 8'h02);
                              check("incr4_b4_master", 8'(hmaster), 8'h0);
    cyc(IDLE, SINGLE, 1'b1);  check("incr4_ho_master", 8'(hmaster), 8'h1);
                              check("incr4_ho_master_d", 8'(hmaster_d), 8'h0);
                              check("incr4_ho_grant", 8'(hgrant), 8'h02);
    cyc(IDLE, SINGLE, 1'b0);  check("stall_master_hold", 8'(hmaster), 8'h1);
                              check("stall_master_d_hold", 8'(hmaster_d), 8'h0);
    cyc(IDLE, SINGLE, 1'b1);  check("incr4_ho_master_d2", 8'(hmaster_d), 8'h1);

    // Return bus to M0, then INCR4 with a 3-cycle stall on beat 3
    hbusreq = 2'b01;
    cyc(IDLE, SINGLE, 1'b1);  check("back_m0_grant", 8'(hgrant), 8'h01);
    cyc(IDLE, SINGLE, 1'b1);  check("back_m0_master", 8'(hmaster), 8'h0);
    cyc(IDLE, SINGLE, 1'b1);  check("back_m0_master_d", 8'(hmaster_d), 8'h0);
    cyc(NONSEQ, INCR4, 1'b1); check("stl_b1_grant", 8'(hgrant), 8'h01);
    hbusreq = 2'b11;
    cyc(SEQ, INCR4, 1'b1);    check("stl_b2_grant", 8'(hgrant), 8'h01);
    for (int i = 0; i < 3; i++) begin
      cyc(SEQ, INCR4, 1'b0);
      check("stl_wait_grant", 8'(hgrant), 8'h01);
      check("stl_wait_master_d", 8'(hmaster_d), 8'h0);
    end
    cyc(SEQ, INCR4, 1'b1);    check("stl_b3_grant", 8'(hgrant), 8'h01);
    hbusreq = 2'b10;
    cyc(SEQ, INCR4, 1'b1);    check("stl_b4_grant", 8'(hgrant), 8'h02);
    cyc(IDLE, SINGLE, 1'b1);  check("stl_ho_master", 8'(hmaster), 8'h1);

    // Both masters request SINGLEs continuously
    hbusreq = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cyc(NONSEQ, SINGLE, 1'b1);
      check("alt_grant", 8'(hgrant), 8'(exp_alt[i]));
    end

    // M1 locks three SINGLEs while M0 requests
    hbusreq = 2'b10;
    cyc(IDLE, SINGLE, 1'b1);  check("lk_pre_grant", 8'(hgrant), 8'h02);
    cyc(IDLE, SINGLE, 1'b1);  check("lk_pre_master", 8'(hmaster), 8'h1);
    hlock = 2'b10;
    hbusreq = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cyc(NONSEQ, SINGLE, 1'b1);
      check("lk_grant", 8'(hgrant), 8'h02);
      check("lk_mastlock", 8'(hmastlock), 8'h1);
    end
    hlock = 2'b00;
    hbusreq = 2'b01;
    cyc(IDLE, SINGLE, 1'b1);  check("lk_drop_grant", 8'(hgrant), 8'h02);
                              check("lk_drop_mastlock", 8'(hmastlock), 8'h0);
    cyc(IDLE, SINGLE, 1'b1);  check("lk_after_grant", 8'(hgrant), 8'h01);

    // WRAP8 by M1, asynchronous reset during beat 5
    hbusreq = 2'b10;
    cyc(IDLE, SINGLE, 1'b1);  check("w8_pre_grant", 8'(hgrant), 8'h02);
    cyc(IDLE, SINGLE, 1'b1);  check("w8_pre_master", 8'(hmaster), 8'h1);
    cyc(IDLE, SINGLE, 1'b1);  check("w8_pre_master_d", 8'(hmaster_d), 8'h1);
    cyc(NONSEQ, WRAP8, 1'b1);
    for (int i = 0; i < 3; i++) cyc(SEQ, WRAP8, 1'b1);
    check("w8_b4_grant", 8'(hgrant), 8'h02);
    hbusreq = 2'b11;
    htrans = SEQ;
    #3;
    hreset = 1'b0;
    #1;
    check("arst_grant", 8'(hgrant), 8'h01);
    check("arst_master", 8'(hmaster), 8'h0);
    check("arst_master_d", 8'(hmaster_d), 8'h0);
    check("arst_mastlock", 8'(hmastlock), 8'h0);
    htrans = IDLE;
    hbusreq = 2'b10;
    #1;
    hreset = 1'b1;

    // Fresh WRAP8 from M1 must hold the bus for exactly 8 beats
    cyc(IDLE, SINGLE, 1'b1);  check("post_grant", 8'(hgrant), 8'h02);
    hbusreq = 2'b11;
    cyc(NONSEQ, WRAP8, 1'b1); check("post_w8_b1_grant", 8'(hgrant), 8'h02);
    for (int i = 0; i < 6; i++) begin
      cyc(SEQ, WRAP8, 1'b1);
      check("post_w8_mid_grant", 8'(hgrant), 8'h02);
    end
    cyc(SEQ, WRAP8, 1'b1);    check("post_w8_last_grant", 8'(hgrant), 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- AHB arbiter that shares one AHB bus among NUM_MASTERS requesters.
- Grants the address phase and tracks burst boundaries, so handover happens only at legal points.
- Drives HMASTER/HMASTLOCK for the address-phase mux and HMASTER_D for the HWDATA/HRDATA data-phase steering.
- Sits between the master ports and the shared AHB interface signals (HADDR/HTRANS/HBURST/HREADY).

Parameters:
- NUM_MASTERS, 2, number of requesters (2..4).
- MW, derived as max(1, clog2(NUM_MASTERS)), width of the master index.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  asynchronous, active-low reset.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  in  2  muxed address-phase transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HBURST  in  3  muxed address-phase burst type.
- HREADY  in  1  bus ready (transfer completes when 1).
- HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  MW  address-phase owner index.
- HMASTER_D  out  MW  data-phase owner index.
- HMASTLOCK  out  1  current address-phase transfer is locked.

Behaviour:
- Reset (HRESET=0, async): HGRANT=1 (master 0, the default master), HMASTER=0, HMASTER_D=0, HMASTLOCK=0, beat counter=0, state=IDLE_BUS.
- HGRANT is always exactly one-hot; with no requests it parks on the last owner.
- Pipeline on HCLK edges with HREADY=1: HMASTER<=index(HGRANT); HMASTLOCK<=HLOCK[index(HGRANT)]; HMASTER_D<=HMASTER.
- With HREADY=0, HMASTER, HMASTER_D and HMASTLOCK all hold.
- Beat counter (remaining beats after the current one), updated only when HREADY=1:
  - NONSEQ loads len-1: SINGLE=0, INCR=0, WRAP4/INCR4=3, WRAP8/INCR8=7, WRAP16/INCR16=15.
  - SEQ decrements, saturating at 0.
  - BUSY and IDLE hold the count.
- States:
  - IDLE_BUS: no transfer in progress.
  - BURST: fixed-length burst, counter>0.
  - INCR_OPEN: undefined-length INCR in progress.
  - LOCKED: HLOCK of the owner is asserted.
- Arbitration point: a cycle with HREADY=1 and any of:
  - HTRANS=IDLE;
  - NONSEQ/SEQ that leaves the counter at 0 (state not BURST after update);
  - state INCR_OPEN and HBUSREQ[owner]=0.
  - No arbitration point while state=LOCKED or HLOCK[owner]=1.
- At an arbitration point, the next HGRANT is the round-robin winner: search indices owner+1 … owner+NUM_MASTERS (mod). The owner keeps the grant if it is the only requester or no one requests. It takes effect at the following edge.
- Transitions:
  - IDLE_BUS→BURST on NONSEQ with fixed burst.
  - →INCR_OPEN on NONSEQ with INCR.
  - BURST→IDLE_BUS when the counter reaches 0.
  - any→LOCKED when HLOCK[owner]=1.
  - LOCKED→IDLE_BUS when HLOCK[owner]=0 and an HREADY=1 transfer completes.
- BUSY beats never create an arbitration point.
- Simultaneous events:
  - Requests arriving mid-burst wait; the grant changes only at the point above.
  - If a requester drops HBUSREQ before its grant, it is simply skipped.
- An early NONSEQ inside a fixed burst (an early-terminated burst) reloads the counter for the new burst.
- Reset mid-burst returns immediately to the reset values.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority; the lowest-index requester wins at each arbitration point. Lock and burst rules are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset released, no requests, HTRANS=IDLE → HGRANT=01, HMASTER=0, HMASTER_D=0, HMASTLOCK=0, stable for 10 cycles.
- M0 issues INCR4 (NONSEQ+3 SEQ, HREADY=1); M1 requests at beat 2 → HGRANT=10 is seen only after the 4th beat's address phase; HMASTER=1 one edge later; HMASTER_D=1 one further edge later.
- Same as above, with HREADY=0 for 3 cycles on beat 3 → grant change is delayed by exactly 3 cycles; HMASTER_D holds during the stall.
- Both masters request continuously with SINGLE transfers → grants alternate 01,10,01,10 (with ARB_FIXED_PRIO_EN: stays 01).
- M1 holds HLOCK=1 for 3 SINGLE transfers while M0 requests → HMASTLOCK=1 for those 3 transfers and no handover; M0 is granted at the first transfer completion after HLOCK drops.
- HRESET pulsed low mid-WRAP8 at beat 5 with M1 owner → all outputs return to reset values asynchronously; after release, a fresh M1 NONSEQ reloads the counter to 7.
